// File: rtl/multicycle_control_pkg.sv
// Shared types and constants for the multicycle CPU control FSM.
// Optional feature macro: MC_JUMP_EN (enables the j instruction / JUMP state).
package mc_pkg;

   // Opcodes, IR[31:26]
   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_ADDI = 6'b001000;
   localparam logic [5:0] OP_SUBI = 6'b001001;
   localparam logic [5:0] OP_J    = 6'b000010;

   // aluop1/aluop0 encodings seen by the ALU control decoder
   localparam logic [1:0] ALU_ADD   = 2'b00;
   localparam logic [1:0] ALU_SUB   = 2'b01;
   localparam logic [1:0] ALU_FUNCT = 2'b10;

   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_MEMADR = 4'd2,
      S_MEMRD  = 4'd3,
      S_MEMWB  = 4'd4,
      S_MEMWR  = 4'd5,
      S_EXEC   = 4'd6,
      S_RWB    = 4'd7,
      S_BRANCH = 4'd8,
      S_IEXEC  = 4'd9,
      S_IWB    = 4'd10,
      S_JUMP   = 4'd11
   } state_t;

   typedef struct packed {
      logic       pcwrite;
      logic       pcwritecond;
      logic       iord;
      logic       memread;
      logic       memwrite;
      logic       irwrite;
      logic       memtoreg;
      logic       regdst;
      logic       regwrite;
      logic       alusrca;
      logic [1:0] alusrcb;
      logic [1:0] aluop;
      logic [1:0] pcsource;
   } ctrl_t;

   // States that wait on the memory ready handshake (watched by the watchdog)
   function automatic logic is_mem_state(state_t s);
      return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
   endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Control-unit bus: opcode and memory handshake in, datapath controls out.
// master = control unit side, slave = datapath/environment side.
interface multicycle_control_if;
   logic [5:0] op;
   logic       mem_ready;
   logic       pcwrite;
   logic       pcwritecond;
   logic       iord;
   logic       memread;
   logic       memwrite;
   logic       irwrite;
   logic       memtoreg;
   logic       regdst;
   logic       regwrite;
   logic       alusrca;
   logic [1:0] alusrcb;
   logic       aluop1;
   logic       aluop0;
   logic [1:0] pcsource;
   logic       illegal_op;
   logic       mem_timeout;
   logic [3:0] state;

   modport master (
      input  op, mem_ready,
      output pcwrite, pcwritecond, iord, memread, memwrite, irwrite, memtoreg,
             regdst, regwrite, alusrca, alusrcb, aluop1, aluop0, pcsource,
             illegal_op, mem_timeout, state
   );

   modport slave (
      output op, mem_ready,
      input  pcwrite, pcwritecond, iord, memread, memwrite, irwrite, memtoreg,
             regdst, regwrite, alusrca, alusrcb, aluop1, aluop0, pcsource,
             illegal_op, mem_timeout, state
   );
endinterface

// File: rtl/multicycle_control_outdec.sv
// Moore output decoder: state (+subi_q, mem_ready for FETCH gating) -> controls.
// wr_en_i=0 suppresses every write enable (used while reset is asserted).
// JUMP outputs exist only with MC_JUMP_EN.
module mc_outdec
   import mc_pkg::*;
(
   input  state_t state_i,
   input  logic   subi_i,
   input  logic   mem_ready_i,
   input  logic   wr_en_i,
   output ctrl_t  ctrl_o
);

   // Per-state control word; anything not set stays 0
   always_comb begin
      ctrl_t c;
      c = '0;
      case (state_i)
         S_FETCH: begin
            c.memread = 1'b1;
            c.irwrite = mem_ready_i;
            c.pcwrite = mem_ready_i;
            c.alusrcb = 2'b01;
            c.aluop   = ALU_ADD;
         end
         S_DECODE: begin
            c.alusrcb = 2'b11;
            c.aluop   = ALU_ADD;
         end
         S_MEMADR: begin
            c.alusrca = 1'b1;
            c.alusrcb = 2'b10;
            c.aluop   = ALU_ADD;
         end
         S_MEMRD: begin
            c.memread = 1'b1;
            c.iord    = 1'b1;
         end
         S_MEMWB: begin
            c.regwrite = 1'b1;
            c.memtoreg = 1'b1;
         end
         S_MEMWR: begin
            c.memwrite = 1'b1;
            c.iord     = 1'b1;
         end
         S_EXEC: begin
            c.alusrca = 1'b1;
            c.aluop   = ALU_FUNCT;
         end
         S_RWB: begin
            c.regwrite = 1'b1;
            c.regdst   = 1'b1;
         end
         S_BRANCH: begin
            c.alusrca     = 1'b1;
            c.aluop       = ALU_SUB;
            c.pcwritecond = 1'b1;
            c.pcsource    = 2'b01;
         end
         S_IEXEC: begin
            c.alusrca = 1'b1;
            c.alusrcb = 2'b10;
            c.aluop   = subi_i ? ALU_SUB : ALU_ADD;
         end
         S_IWB: begin
            c.regwrite = 1'b1;
         end
`ifdef MC_JUMP_EN
         S_JUMP: begin
            c.pcwrite  = 1'b1;
            c.pcsource = 2'b10;
         end
`endif
         default: c = '0;
      endcase
      if (!wr_en_i) begin
         c.pcwrite     = 1'b0;
         c.pcwritecond = 1'b0;
         c.irwrite     = 1'b0;
         c.memwrite    = 1'b0;
         c.regwrite    = 1'b0;
      end
      ctrl_o = c;
   end

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM of the multicycle CPU: state register, subi flag,
// memory-wait watchdog and the illegal_op / mem_timeout pulse flags.
// Optional feature macro: MC_JUMP_EN (j opcode -> JUMP state; otherwise illegal).
module multicycle_control
   import mc_pkg::*;
#(
   parameter int MEM_WAIT_MAX = 255,
   parameter int CNT_W        = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   multicycle_control_if.master bus
);

   state_t           state_q, state_d;
   logic             subi_q, subi_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             ill_q, ill_d;
   logic             to_q, to_d;
   ctrl_t            ctrl;

   // Next-state, subi capture, watchdog counter and pulse requests
   always_comb begin
      state_d = state_q;
      subi_d  = subi_q;
      cnt_d   = '0;
      ill_d   = 1'b0;
      to_d    = 1'b0;
      case (state_q)
         S_FETCH:  if (bus.mem_ready) state_d = S_DECODE;
         S_DECODE: begin
            subi_d = (bus.op == OP_SUBI);
            case (bus.op)
               OP_LW, OP_SW:     state_d = S_MEMADR;
               OP_R:             state_d = S_EXEC;
               OP_BEQ:           state_d = S_BRANCH;
               OP_ADDI, OP_SUBI: state_d = S_IEXEC;
`ifdef MC_JUMP_EN
               OP_J:             state_d = S_JUMP;
`endif
               default: begin
                  state_d = S_FETCH;
                  ill_d   = 1'b1;
               end
            endcase
         end
         S_MEMADR: state_d = (bus.op == OP_LW) ? S_MEMRD : S_MEMWR;
         S_MEMRD:  if (bus.mem_ready) state_d = S_MEMWB;
         S_MEMWB:  state_d = S_FETCH;
         S_MEMWR:  if (bus.mem_ready) state_d = S_FETCH;
         S_EXEC:   state_d = S_RWB;
         S_RWB:    state_d = S_FETCH;
         S_BRANCH: state_d = S_FETCH;
         S_IEXEC:  state_d = S_IWB;
         S_IWB:    state_d = S_FETCH;
         default:  state_d = S_FETCH;
      endcase
      // A ready cycle always leaves the memory state, so the counter only
      // survives while stalled; on the limit, abort to FETCH (refetch in FETCH).
      if (is_mem_state(state_q) && !bus.mem_ready) begin
         if (cnt_q == CNT_W'(MEM_WAIT_MAX)) begin
            state_d = S_FETCH;
            to_d    = 1'b1;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   // State and flag registers, synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_FETCH;
         subi_q  <= 1'b0;
         cnt_q   <= '0;
         ill_q   <= 1'b0;
         to_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         subi_q  <= subi_d;
         cnt_q   <= cnt_d;
         ill_q   <= ill_d;
         to_q    <= to_d;
      end
   end

   mc_outdec u_outdec (
      .state_i    (state_q),
      .subi_i     (subi_q),
      .mem_ready_i(bus.mem_ready),
      .wr_en_i    (rst_n),
      .ctrl_o     (ctrl)
   );

   assign bus.pcwrite     = ctrl.pcwrite;
   assign bus.pcwritecond = ctrl.pcwritecond;
   assign bus.iord        = ctrl.iord;
   assign bus.memread     = ctrl.memread;
   assign bus.memwrite    = ctrl.memwrite;
   assign bus.irwrite     = ctrl.irwrite;
   assign bus.memtoreg    = ctrl.memtoreg;
   assign bus.regdst      = ctrl.regdst;
   assign bus.regwrite    = ctrl.regwrite;
   assign bus.alusrca     = ctrl.alusrca;
   assign bus.alusrcb     = ctrl.alusrcb;
   assign bus.aluop1      = ctrl.aluop[1];
   assign bus.aluop0      = ctrl.aluop[0];
   assign bus.pcsource    = ctrl.pcsource;
   assign bus.illegal_op  = ill_q;
   assign bus.mem_timeout = to_q;
   assign bus.state       = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: per-instruction expected state paths are built
// from the instruction class and chosen stall counts, then replayed cycle by
// cycle against the DUT. Directed cases first, then random instructions.
module tb_multicycle_control;

   localparam int MAXW = 4;

   localparam logic [5:0] T_R = 6'b000000, T_LW = 6'b100011, T_SW = 6'b101011,
                          T_BEQ = 6'b000100, T_ADDI = 6'b001000, T_SUBI = 6'b001001,
                          T_J = 6'b000010, T_BAD = 6'b111111;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   multicycle_control_if bus();

   multicycle_control #(.MEM_WAIT_MAX(MAXW), .CNT_W(8)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   int errs = 0;
   int checks = 0;

   typedef struct {
      int st;
      bit rdy;
      bit ill;
      bit to;
      bit sb;
   } step_t;

   step_t q[$];
   bit pend_ill = 0, pend_to = 0, cur_sb = 0;

   // Expected control word straight from the per-state table
   function automatic logic [15:0] exp_ctrl(int st, bit sb, bit rdy, bit wr);
      bit pcw = 0, pcwc = 0, iord = 0, mr = 0, mw = 0, irw = 0, m2r = 0, rd = 0, rw = 0, asa = 0;
      bit [1:0] asb = 0, aop = 0, pcs = 0;
      case (st)
         0:  begin mr = 1; irw = rdy; pcw = rdy; asb = 2'b01; end
         1:  asb = 2'b11;
         2:  begin asa = 1; asb = 2'b10; end
         3:  begin mr = 1; iord = 1; end
         4:  begin rw = 1; m2r = 1; end
         5:  begin mw = 1; iord = 1; end
         6:  begin asa = 1; aop = 2'b10; end
         7:  begin rw = 1; rd = 1; end
         8:  begin asa = 1; aop = 2'b01; pcwc = 1; pcs = 2'b01; end
         9:  begin asa = 1; asb = 2'b10; aop = sb ? 2'b01 : 2'b00; end
         10: rw = 1;
         11: begin pcw = 1; pcs = 2'b10; end
         default: ;
      endcase
      if (!wr) begin pcw = 0; pcwc = 0; irw = 0; rw = 0; mw = 0; end
      return {pcw, pcwc, iord, mr, mw, irw, m2r, rd, rw, asa, asb, aop, pcs};
   endfunction

   function automatic logic [15:0] act_ctrl();
      return {bus.pcwrite, bus.pcwritecond, bus.iord, bus.memread, bus.memwrite,
              bus.irwrite, bus.memtoreg, bus.regdst, bus.regwrite, bus.alusrca,
              bus.alusrcb, bus.aluop1, bus.aluop0, bus.pcsource};
   endfunction

   task automatic chk(input string tag, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      assert (act === exp) else begin
         errs++;
         $error("FAIL %s at %0t: got=%h exp=%h", tag, $time, act, exp);
      end
   endtask

   // 0 R, 1 lw, 2 sw, 3 beq, 4 addi/subi, 5 j, 6 illegal
   function automatic int kind(logic [5:0] op);
      case (op)
         T_R:            return 0;
         T_LW:           return 1;
         T_SW:           return 2;
         T_BEQ:          return 3;
         T_ADDI, T_SUBI: return 4;
`ifdef MC_JUMP_EN
         T_J:            return 5;
`endif
         default:        return 6;
      endcase
   endfunction

   task automatic push(input int st, input bit rdy);
      step_t s;
      s.st = st; s.rdy = rdy; s.ill = pend_ill; s.to = pend_to; s.sb = cur_sb;
      q.push_back(s);
      pend_ill = 0;
      pend_to = 0;
   endtask

   // stalls > MAXW means the watchdog fires: MAXW+1 idle cycles, then abort
   task automatic mem_wait(input int st, input int stalls, output bit aborted);
      aborted = 0;
      if (stalls > MAXW) begin
         for (int i = 0; i <= MAXW; i++) push(st, 0);
         pend_to = 1;
         aborted = 1;
      end else begin
         for (int i = 0; i < stalls; i++) push(st, 0);
         push(st, 1);
      end
   endtask

   task automatic build(input logic [5:0] op, input int fs, input int ms);
      bit ab;
      mem_wait(0, fs, ab);
      if (ab) mem_wait(0, int'($urandom_range(0, 2)), ab);
      push(1, 1'($urandom));
      if (op == T_SUBI) cur_sb = 1;
      else if (kind(op) != 6) cur_sb = 0;
      else cur_sb = 0;
      case (kind(op))
         0: begin push(6, 1'($urandom)); push(7, 1'($urandom)); end
         1: begin push(2, 1'($urandom)); mem_wait(3, ms, ab); if (!ab) push(4, 1'($urandom)); end
         2: begin push(2, 1'($urandom)); mem_wait(5, ms, ab); end
         3: push(8, 1'($urandom));
         4: begin push(9, 1'($urandom)); push(10, 1'($urandom)); end
         5: push(11, 1'($urandom));
         default: pend_ill = 1;
      endcase
   endtask

   // Called just after a rising edge; each step is exactly one clock
   task automatic play();
      step_t s;
      while (q.size() > 0) begin
         s = q.pop_front();
         bus.mem_ready = s.rdy;
         #1;
         chk("state", 16'(bus.state), 16'(s.st));
         chk("ctrl", act_ctrl(), exp_ctrl(s.st, s.sb, s.rdy, 1'b1));
         chk("illegal_op", 16'(bus.illegal_op), 16'(s.ill));
         chk("mem_timeout", 16'(bus.mem_timeout), 16'(s.to));
         @(posedge clk);
         #1;
      end
   endtask

   task automatic run(input logic [5:0] op, input int fs, input int ms);
      bus.op = op;
      build(op, fs, ms);
      play();
   endtask

   task automatic chk_reset_cycle(input string tag, input bit rdy);
      chk({tag, "_state"}, 16'(bus.state), 16'd0);
      chk({tag, "_ctrl"}, act_ctrl(), exp_ctrl(0, 0, rdy, 1'b0));
      chk({tag, "_ill"}, 16'(bus.illegal_op), 16'd0);
      chk({tag, "_to"}, 16'(bus.mem_timeout), 16'd0);
   endtask

   logic [5:0] ops [8];

   initial begin
      bus.op = T_R;
      bus.mem_ready = 1'b1;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk_reset_cycle("reset", 1'b1);
      rst_n = 1'b1;

      run(T_R, 0, 0);
      run(T_LW, 0, 3);
      run(T_BEQ, 0, 0);
      run(T_SUBI, 0, 0);
      run(T_ADDI, 0, 0);
      run(T_BAD, 0, 0);
      run(T_SW, 0, MAXW + 1);
      run(T_J, 0, 0);
      run(T_LW, MAXW, MAXW);
      run(T_SW, 1, MAXW);
      run(T_R, MAXW + 1, 0);
      run(T_LW, 0, MAXW + 1);
      run(T_R, 0, 0);

      // reset while stalled in MEMRD
      bus.op = T_LW;
      push(0, 1); push(1, 0); push(2, 0); push(3, 0); push(3, 0);
      play();
      rst_n = 1'b0;
      bus.mem_ready = 1'b0;
      @(posedge clk);
      #1;
      chk_reset_cycle("rst_memrd", 1'b0);
      rst_n = 1'b1;

      // reset while stalled in FETCH; afterwards a full MAXW stall must not time out
      push(0, 0); push(0, 0); push(0, 0);
      play();
      rst_n = 1'b0;
      bus.mem_ready = 1'b0;
      @(posedge clk);
      #1;
      chk_reset_cycle("rst_fetch", 1'b0);
      rst_n = 1'b1;
      run(T_R, MAXW, 0);

      ops = '{T_R, T_LW, T_SW, T_BEQ, T_ADDI, T_SUBI, T_J, T_BAD};
      repeat (80) begin
         logic [5:0] op;
         int sel;
         sel = int'($urandom_range(0, 8));
         op = (sel == 8) ? 6'($urandom) : ops[sel];
         run(op, int'($urandom_range(0, MAXW + 1)), int'($urandom_range(0, MAXW + 1)));
      end

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
